// File: rtl/stack_arb_pkg.sv
// Shared encodings for the two-requester stack sequencer.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    // A push into a full stack or a pop from an empty one must never reach the stack.
    function automatic logic op_illegal(input logic op, input logic is_full, input logic is_empty);
        return (op == OP_PUSH) ? is_full : is_empty;
    endfunction

endpackage

// File: rtl/stack_arbiter_arb2_rr.sv
// Two-input arbiter: round-robin when STACK_ARB_RR_EN is defined, otherwise fixed priority to req 0.
module arb2_rr
    import stack_arb_pkg::*;
(
`ifdef STACK_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef STACK_ARB_RR_EN
    // ptr_q = 1 means requester 1 is preferred on a tie.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[REQ0] && (!req_i[REQ1] || !ptr_q)) begin
            gnt_o[REQ0] = 1'b1;
        end else if (req_i[REQ1]) begin
            gnt_o[REQ1] = 1'b1;
        end
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = gnt_o[REQ0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_o = 2'b00;
        gnt_o[REQ0] = req_i[REQ0];
        gnt_o[REQ1] = req_i[REQ1] & ~req_i[REQ0];
    end
`endif

endmodule

// File: rtl/stack_arbiter.sv
// Shares a flagless hardware stack between two requesters, tracking occupancy and rejecting
// overflow/underflow. Arbitration mode selected by STACK_ARB_RR_EN (see arb2_rr).
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             ack0,
    output logic             err0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack1,
    output logic             err1,
    output logic [WIDTH-1:0] rdata1,
    output logic             stk_en,
    output logic             stk_c,
    output logic [WIDTH-1:0] stk_push,
    input  logic [WIDTH-1:0] stk_peek,
    output logic [DEPTH:0]   count,
    output logic             full,
    output logic             empty
);

    localparam int           CAP   = 2 ** DEPTH;
    localparam logic [DEPTH:0] CAP_W = CAP[DEPTH:0];
    localparam logic [DEPTH:0] ONE   = {{DEPTH{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             sel_q, op_q, err_q;
    logic [WIDTH-1:0] wdata_q, cap_q, rdata0_q, rdata1_q;
    logic [DEPTH:0]   count_q, count_d;
    logic             full_q, empty_q;

    logic [1:0]       req, gnt;
    logic             grant, g_sel, g_op;
    logic [WIDTH-1:0] g_wdata;

    assign req = {req1, req0};

    arb2_rr u_arb (
`ifdef STACK_ARB_RR_EN
        .clk   (clk),
        .rst_n (clr),
        .adv_i (grant),
`endif
        .req_i (req),
        .gnt_o (gnt)
    );

    always_comb begin
        grant   = (state_q == ST_IDLE) && (gnt != 2'b00);
        g_sel   = gnt[REQ1];
        g_op    = g_sel ? op1 : op0;
        g_wdata = g_sel ? wdata1 : wdata0;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = op_illegal(g_op, full_q, empty_q) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_SETTLE;
                count_d = (op_q == OP_POP) ? (count_q - ONE) : (count_q + ONE);
            end
            ST_SETTLE: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            op_q     <= OP_PUSH;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            cap_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (grant) begin
                sel_q   <= g_sel;
                op_q    <= g_op;
                wdata_q <= g_wdata;
                err_q   <= op_illegal(g_op, full_q, empty_q);
            end
            // Peek still shows the old top during ISSUE; the stack updates at this edge.
            if (state_q == ST_ISSUE) begin
                full_q  <= (count_d == CAP_W);
                empty_q <= (count_d == '0);
                if (op_q == OP_POP) begin
                    cap_q <= stk_peek;
                end
            end
            // Publish popped data together with the ack so rdata holds between acks.
            if ((state_q == ST_SETTLE) && (op_q == OP_POP)) begin
                if (sel_q) begin
                    rdata1_q <= cap_q;
                end else begin
                    rdata0_q <= cap_q;
                end
            end
        end
    end

    assign stk_en   = (state_q == ST_ISSUE);
    assign stk_c    = stk_en & op_q;
    assign stk_push = stk_en ? wdata_q : '0;

    assign ack0   = (state_q == ST_RESP) && !sel_q;
    assign ack1   = (state_q == ST_RESP) &&  sel_q;
    assign err0   = ack0 & err_q;
    assign err1   = ack1 & err_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule
